// File: rtl/fpalu_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : fpalu_arb_if
// Description : Requester, FPALU and response signal bundle for the
//               two-requester FPALU arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface fpalu_arb_if;
    // requester 0
    logic        req0_valid;
    logic        req0_ready;
    logic [1:0]  req0_opcode;
    logic [28:0] req0_a;
    logic [28:0] req0_b;
    // requester 1
    logic        req1_valid;
    logic        req1_ready;
    logic [1:0]  req1_opcode;
    logic [28:0] req1_a;
    logic [28:0] req1_b;
    // FPALU side
    logic [1:0]  alu_opcode;
    logic [28:0] alu_a;
    logic [28:0] alu_b;
    logic [28:0] alu_y;
    // responses
    logic        rsp0_valid;
    logic        rsp1_valid;
    logic [28:0] rsp_y;
    logic        busy;

    // requesters plus the FPALU result path
    modport master (
        output req0_valid, req0_opcode, req0_a, req0_b,
        output req1_valid, req1_opcode, req1_a, req1_b,
        output alu_y,
        input  req0_ready, req1_ready,
        input  alu_opcode, alu_a, alu_b,
        input  rsp0_valid, rsp1_valid, rsp_y, busy
    );

    // the arbiter
    modport slave (
        input  req0_valid, req0_opcode, req0_a, req0_b,
        input  req1_valid, req1_opcode, req1_a, req1_b,
        input  alu_y,
        output req0_ready, req1_ready,
        output alu_opcode, alu_a, alu_b,
        output rsp0_valid, rsp1_valid, rsp_y, busy
    );
endinterface
`default_nettype wire

// File: rtl/fpalu_arb.sv
`default_nettype none
// ============================================================================
// Module      : fpalu_arb
// Description : Round-robin arbiter sharing one pipelined FPALU between two
//               requesters. Tracks in-flight operations in a LAT+1 deep
//               tag shift register and routes each result back to its owner
//               in issue order. Optionally drains the pipeline before an
//               opcode change.
// Revision    : 1.0 - initial release
// ============================================================================
module fpalu_arb #(
    parameter int LAT               = 2,
    parameter bit DRAIN_ON_OPSWITCH = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    fpalu_arb_if.slave bus
);

    localparam logic [1:0] C_OP_ADD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t       r_state;
    logic         r_ptr;
    logic [LAT:0] r_trk_vld;
    logic [LAT:0] r_trk_tag;

    logic         w_busy;
    logic         w_win_vld;
    logic         w_win_id;
    logic [1:0]   w_win_op;
    logic [28:0]  w_win_a;
    logic [28:0]  w_win_b;
    logic         w_opswitch;
    logic         w_stall;
    logic         w_accept;

    // Pick the round-robin winner and decide whether it may issue this cycle.
    // Ready is gated by rst_n so it reads low for the whole reset window.
    always_comb begin
        w_win_vld = bus.req0_valid | bus.req1_valid;
        if (r_ptr == 1'b0) begin
            w_win_id = bus.req0_valid ? 1'b0 : 1'b1;
        end else begin
            w_win_id = bus.req1_valid ? 1'b1 : 1'b0;
        end
        w_win_op   = w_win_id ? bus.req1_opcode : bus.req0_opcode;
        w_win_a    = w_win_id ? bus.req1_a      : bus.req0_a;
        w_win_b    = w_win_id ? bus.req1_b      : bus.req0_b;
        w_busy     = |r_trk_vld;
        // an opcode change may not enter a pipeline still holding the old opcode
        w_opswitch = DRAIN_ON_OPSWITCH && w_win_vld && w_busy
                     && (w_win_op != bus.alu_opcode);
        // once draining, hold both requesters off until the pipeline is empty
        w_stall    = w_opswitch || ((r_state == ST_DRAIN) && w_busy);
        w_accept   = rst_n && w_win_vld && !w_stall;
        bus.req0_ready = w_accept && !w_win_id;
        bus.req1_ready = w_accept &&  w_win_id;
        bus.busy       = w_busy;
    end

    // Control FSM, priority pointer, operand registers, tracking shift
    // register and registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_ptr          <= 1'b0;
            r_trk_vld      <= '0;
            r_trk_tag      <= '0;
            bus.alu_opcode <= C_OP_ADD;
            bus.alu_a      <= '0;
            bus.alu_b      <= '0;
            bus.rsp0_valid <= 1'b0;
            bus.rsp1_valid <= 1'b0;
            bus.rsp_y      <= '0;
        end else begin
            // slot 0 records this cycle's issue; the tail slot is the
            // operation whose result is on alu_y now
            r_trk_vld <= {r_trk_vld[LAT-1:0], w_accept};
            r_trk_tag <= {r_trk_tag[LAT-1:0], w_win_id};

            if (w_accept) begin
                bus.alu_opcode <= w_win_op;
                bus.alu_a      <= w_win_a;
                bus.alu_b      <= w_win_b;
                r_ptr          <= ~w_win_id;
            end

            bus.rsp0_valid <= r_trk_vld[LAT] && !r_trk_tag[LAT];
            bus.rsp1_valid <= r_trk_vld[LAT] &&  r_trk_tag[LAT];
            if (r_trk_vld[LAT]) begin
                bus.rsp_y <= bus.alu_y;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_opswitch) begin
                        r_state <= ST_DRAIN;
                    end else if (!w_accept && !w_busy) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (w_accept) begin
                        r_state <= ST_RUN;
                    end else if (!w_busy && !w_win_vld) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpalu_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpalu_arb
// Description : Self-checking bench for fpalu_arb. A stand-in FPALU pipeline
//               produces alu_y; a model of the arbitration rules predicts
//               every ready and pushes expected results to a scoreboard that
//               is popped when the response is due.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpalu_arb;

    localparam int         LAT      = 2;
    localparam bit         DRAIN    = 1'b1;
    localparam logic [1:0] OP_ADD   = 2'b11;
    localparam logic [1:0] OP_MUL   = 2'b10;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    fpalu_arb_if bus ();

    fpalu_arb #(.LAT(LAT), .DRAIN_ON_OPSWITCH(DRAIN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // stand-in FPALU: fixed function, LAT register stages
    // ------------------------------------------------------------------
    function automatic logic [28:0] fpalu_model(input logic [1:0] op,
                                                input logic [28:0] a,
                                                input logic [28:0] b);
        logic [57:0] p;
        p = {29'b0, a} * {29'b0, b};
        case (op)
            OP_ADD:  return 29'(a + b);
            OP_MUL:  return p[28:0];
            default: return a ^ b;
        endcase
    endfunction

    logic [28:0] alu_pipe [LAT];
    always @(posedge clk) begin
        alu_pipe[0] <= fpalu_model(bus.alu_opcode, bus.alu_a, bus.alu_b);
        for (int i = 1; i < LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
    end
    assign bus.alu_y = alu_pipe[LAT-1];

    // ------------------------------------------------------------------
    // checking
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // requester state and driving
    // ------------------------------------------------------------------
    logic        rv  [2];
    logic [1:0]  rop [2];
    logic [28:0] ra  [2];
    logic [28:0] rb  [2];

    task automatic apply();
        bus.req0_valid = rv[0]; bus.req0_opcode = rop[0]; bus.req0_a = ra[0]; bus.req0_b = rb[0];
        bus.req1_valid = rv[1]; bus.req1_opcode = rop[1]; bus.req1_a = ra[1]; bus.req1_b = rb[1];
    endtask

    task automatic new_op(input int n, input int mode);
        rv[n]  = 1'b1;
        rop[n] = (mode == 0) ? OP_ADD : (mode == 1) ? OP_MUL :
                 (($urandom_range(0, 1) == 0) ? OP_ADD : OP_MUL);
        ra[n]  = 29'($urandom);
        rb[n]  = 29'($urandom);
    endtask

    // ------------------------------------------------------------------
    // reference model + scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        logic        tag;
        logic [28:0] y;
        int          due;
    } sb_t;

    sb_t        sb [$];
    logic       m_ptr;
    logic [1:0] m_aluop;
    logic       m_drain;

    task automatic model_reset();
        sb.delete();
        m_ptr   = 1'b0;
        m_aluop = OP_ADD;
        m_drain = 1'b0;
    endtask

    logic        mv_any, mv_win, mv_busy, mv_opsw, mv_stall;
    logic [1:0]  mv_op, mv_rv, mv_rdy;
    logic [28:0] mv_a, mv_b;

    // per-cycle prediction of responses, busy and grants
    always @(negedge clk) begin
        if (rst_n) begin
            mv_rv = 2'b00;
            if (sb.size() != 0 && sb[0].due == cyc) mv_rv = sb[0].tag ? 2'b10 : 2'b01;
            check("rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, mv_rv);
            if (mv_rv != 2'b00) begin
                check("rsp_y", bus.rsp_y, sb[0].y);
                void'(sb.pop_front());
            end

            mv_busy = (sb.size() != 0);
            check("busy", bus.busy, mv_busy);

            mv_any = bus.req0_valid | bus.req1_valid;
            mv_win = m_ptr ? (bus.req1_valid ? 1'b1 : 1'b0) : (bus.req0_valid ? 1'b0 : 1'b1);
            mv_op  = mv_win ? bus.req1_opcode : bus.req0_opcode;
            mv_a   = mv_win ? bus.req1_a : bus.req0_a;
            mv_b   = mv_win ? bus.req1_b : bus.req0_b;
            mv_opsw  = DRAIN && mv_any && mv_busy && (mv_op != m_aluop);
            mv_stall = mv_opsw || (m_drain && mv_busy);
            mv_rdy   = (mv_any && !mv_stall) ? (mv_win ? 2'b10 : 2'b01) : 2'b00;
            check("ready", {bus.req1_ready, bus.req0_ready}, mv_rdy);

            if (mv_rdy != 2'b00) begin
                sb.push_back('{tag: mv_win, y: fpalu_model(mv_op, mv_a, mv_b), due: cyc + LAT + 2});
                m_ptr   = ~mv_win;
                m_aluop = mv_op;
                m_drain = 1'b0;
            end else if (mv_opsw) begin
                m_drain = 1'b1;
            end else if (!mv_busy) begin
                m_drain = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // scenario helpers
    // ------------------------------------------------------------------
    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},  {bus.req1_ready, bus.req0_ready}, 2'b00);
        check({tag, "_rspv"},   {bus.rsp1_valid, bus.rsp0_valid}, 2'b00);
        check({tag, "_busy"},   bus.busy, 1'b0);
        check({tag, "_aluop"},  bus.alu_opcode, OP_ADD);
        check({tag, "_alua"},   bus.alu_a, 29'd0);
        check({tag, "_alub"},   bus.alu_b, 29'd0);
        check({tag, "_rspy"},   bus.rsp_y, 29'd0);
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        rv[0] = 1'b0; rv[1] = 1'b0;
        apply();
        repeat (LAT + 4) @(posedge clk);
        #1;
    endtask

    // requesters hold each operation until accepted; pct is the chance of
    // offering a new one once the previous was taken
    task automatic run_req(input int ncyc, input int pct, input int mode,
                           output int n_acc, output int n_add, output int n_mul);
        logic g [2];
        n_acc = 0; n_add = 0; n_mul = 0;
        g[0] = 1'b0; g[1] = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk); #1;
            for (int n = 0; n < 2; n++) begin
                if (!rv[n] || g[n]) begin
                    if (int'($urandom_range(0, 99)) < pct) new_op(n, mode);
                    else rv[n] = 1'b0;
                end
            end
            apply();
            @(negedge clk);
            g[0] = bus.req0_ready;
            g[1] = bus.req1_ready;
            for (int n = 0; n < 2; n++) begin
                if (g[n]) begin
                    n_acc++;
                    if (rop[n] == OP_ADD) n_add++;
                    else n_mul++;
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    // stimulus
    // ------------------------------------------------------------------
    int n_acc, n_add, n_mul, tot_add, tot_mul, stall_n, chunks;

    initial begin
        rst_n = 1'b0;
        for (int n = 0; n < 2; n++) begin
            rv[n] = 1'b0; rop[n] = OP_ADD; ra[n] = '0; rb[n] = '0;
        end
        apply();
        model_reset();

        // reset state, with a request already pending
        repeat (3) @(posedge clk);
        #1;
        rv[0] = 1'b1; rop[0] = OP_ADD; ra[0] = 29'h0820_0000; rb[0] = 29'h0820_0000;
        apply();
        #1;
        check_reset_outputs("rst");

        // single ADD from requester 0, accepted on the first edge after release
        rst_n = 1'b1;
        @(posedge clk); #1;
        rv[0] = 1'b0;
        apply();
        repeat (LAT + 4) @(posedge clk);
        #1;

        // both requesters streaming the same opcode: one issue every cycle
        run_req(12, 100, 0, n_acc, n_add, n_mul);
        check("issue_rate", n_acc, 12);
        go_idle();

        // ADD then MUL: the MUL waits for the pipeline to empty
        rv[0] = 1'b1; rop[0] = OP_ADD; ra[0] = 29'h0123_4567; rb[0] = 29'h0010_0001;
        apply();
        @(posedge clk); #1;
        rop[0] = OP_MUL; ra[0] = 29'h0000_3039; rb[0] = 29'h0000_0101;
        apply();
        stall_n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.req0_ready) break;
            stall_n++;
        end
        check("drain_len", stall_n, LAT + 1);
        go_idle();

        // requester 1 offers a conflicting op during drain and withdraws it
        rv[0] = 1'b1; rop[0] = OP_ADD; ra[0] = 29'h0000_0011; rb[0] = 29'h0000_0022;
        apply();
        @(posedge clk); #1;
        rv[0] = 1'b0;
        rv[1] = 1'b1; rop[1] = OP_MUL; ra[1] = 29'h0000_0005; rb[1] = 29'h0000_0007;
        apply();
        @(posedge clk); #1;
        rv[1] = 1'b0;
        apply();
        run_req(LAT + 6, 100, 0, n_acc, n_add, n_mul);
        go_idle();

        // reset with two operations in flight
        rv[0] = 1'b1; rop[0] = OP_ADD; ra[0] = 29'h0000_0100; rb[0] = 29'h0000_0200;
        rv[1] = 1'b1; rop[1] = OP_ADD; ra[1] = 29'h0000_0300; rb[1] = 29'h0000_0400;
        apply();
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("midrst");
        rv[0] = 1'b0; rv[1] = 1'b0;
        apply();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (LAT + 4) @(posedge clk);
        #1;

        // random traffic until both opcodes have enough accepted operations
        tot_add = 0; tot_mul = 0; chunks = 0;
        while ((tot_add < 200 || tot_mul < 200) && chunks < 200) begin
            run_req(100, 60, 2, n_acc, n_add, n_mul);
            tot_add += n_add;
            tot_mul += n_mul;
            chunks++;
        end
        check("rand_done", (tot_add >= 200 && tot_mul >= 200), 1'b1);
        go_idle();
        check("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
